// File: rtl/weight_load_ctrl_pkg.sv
// weight_load_ctrl_pkg: mode encodings, FSM states and weight-table constants
package weight_load_ctrl_pkg;
  typedef enum logic [2:0] {
    MODE_CONV   = 3'd0,
    MODE_SPARSE = 3'd1,
    MODE_DW     = 3'd2,
    MODE_FC     = 3'd3,
    MODE_CONVP  = 3'd4,
    MODE_DWALT  = 3'd5
  } mode_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DONE} state_e;
  localparam logic [1:0] WR_CNT_SPARSE = 2'd2;
  localparam logic [1:0] WR_CNT_DW16   = 2'd3;
  localparam logic [1:0] WR_CNT_DW8    = 2'd1;
  localparam logic [2:0] SEQ_MAX_SP16  = 3'd3;
  localparam logic [2:0] SEQ_MAX_SP8   = 3'd1;
  localparam logic [2:0] SEQ_MAX_DW    = 3'd4;
endpackage

// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if: config, line-buffer, weight-register and datapath handshake bundle
interface weight_load_ctrl_if #(parameter int CNT_W = 16);
  logic             cfg_start;
  logic             cfg_abort;
  logic [2:0]       cfg_mode;
  logic             cfg_double_byte;
  logic [CNT_W-1:0] cfg_group_num;
  logic             lb_rd_req;
  logic             lb_rd_vld;
  logic             weight_wr_vld;
  logic [1:0]       weight_reg_wr_cnt;
  logic             conv3d_start;
  logic [2:0]       weight_out_sequence;
  logic             step_en;
  logic             busy;
  logic [CNT_W-1:0] group_idx;
  logic             done;
  modport master (
    output cfg_start, cfg_abort, cfg_mode, cfg_double_byte, cfg_group_num, lb_rd_vld, step_en,
    input  lb_rd_req, weight_wr_vld, weight_reg_wr_cnt, conv3d_start, weight_out_sequence,
           busy, group_idx, done
  );
  modport slave (
    input  cfg_start, cfg_abort, cfg_mode, cfg_double_byte, cfg_group_num, lb_rd_vld, step_en,
    output lb_rd_req, weight_wr_vld, weight_reg_wr_cnt, conv3d_start, weight_out_sequence,
           busy, group_idx, done
  );
endinterface

// File: rtl/weight_load_ctrl_decode.sv
// weight_load_ctrl_decode: mode/precision -> beats-per-group minus 1 and last slice index
module weight_load_ctrl_decode
  import weight_load_ctrl_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic       dbl_i,
  output logic [1:0] wr_cnt_o,
  output logic [2:0] seq_max_o
);
  logic dw;
  assign dw = (mode_i == MODE_DW) || (mode_i == MODE_DWALT);
  always_comb begin
    wr_cnt_o  = (mode_i == MODE_SPARSE) ? WR_CNT_SPARSE :
                dw ? (dbl_i ? WR_CNT_DW16 : WR_CNT_DW8) : 2'd0;
    seq_max_o = (mode_i == MODE_SPARSE) ? (dbl_i ? SEQ_MAX_SP16 : SEQ_MAX_SP8) :
                dw ? SEQ_MAX_DW : 3'd0;
  end
endmodule

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: per-group weight fetch, conv3d kick-off and slice stepping for one job
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rstn,
  weight_load_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic             dbl_q, dbl_d;
  logic [CNT_W-1:0] gnum_q, gnum_d;
  logic [CNT_W-1:0] gidx_q, gidx_d;
  logic [1:0]       beat_q, beat_d;
  logic [2:0]       seq_q, seq_d;
  logic [1:0]       wr_cnt;
  logic [2:0]       seq_max;
  logic [CNT_W-1:0] gmax;
  logic             last;
  weight_load_ctrl_decode u_dec (
    .mode_i   (mode_q),
    .dbl_i    (dbl_q),
    .wr_cnt_o (wr_cnt),
    .seq_max_o(seq_max)
  );
  // a zero group count runs a single group
  assign gmax = (gnum_q == '0) ? '0 : gnum_q - 1'b1;
  assign last = gidx_q == gmax;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      dbl_q   <= 1'b0;
      gnum_q  <= '0;
      gidx_q  <= '0;
      beat_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dbl_q   <= dbl_d;
      gnum_q  <= gnum_d;
      gidx_q  <= gidx_d;
      beat_q  <= beat_d;
      seq_q   <= seq_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dbl_d   = dbl_q;
    gnum_d  = gnum_q;
    gidx_d  = gidx_q;
    beat_d  = beat_q;
    seq_d   = seq_q;
    if (bus.cfg_abort) begin
      state_d = S_IDLE;
      gidx_d  = '0;
      beat_d  = '0;
      seq_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.cfg_start) begin
          state_d = S_LOAD;
          mode_d  = bus.cfg_mode;
          dbl_d   = bus.cfg_double_byte;
          gnum_d  = bus.cfg_group_num;
        end
        S_LOAD: if (bus.lb_rd_vld) begin
          beat_d  = (beat_q == wr_cnt) ? 2'd0 : beat_q + 2'd1;
          state_d = (beat_q == wr_cnt) ? S_START : S_LOAD;
        end
        S_START: begin
          seq_d   = '0;
          state_d = S_RUN;
        end
        S_RUN: if (bus.step_en) begin
          seq_d = (seq_q < seq_max) ? seq_q + 3'd1 : 3'd0;
          if (seq_q >= seq_max) begin
            state_d = last ? S_DONE : S_LOAD;
            gidx_d  = last ? gidx_q : gidx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          gidx_d  = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  assign bus.lb_rd_req           = state_q == S_LOAD;
  assign bus.weight_wr_vld       = bus.lb_rd_vld && (state_q == S_LOAD);
  assign bus.weight_reg_wr_cnt   = wr_cnt;
  assign bus.conv3d_start        = state_q == S_START;
  assign bus.weight_out_sequence = seq_q;
  assign bus.busy                = state_q != S_IDLE;
  assign bus.group_idx           = gidx_q;
  assign bus.done                = state_q == S_DONE;
endmodule
